fft_lane_merge: RTL



---
 rtl/fft_lane_merge_pkg.sv | 11 +
 rtl/fft_lane_merge_lane.sv | 77 +++++++
 rtl/fft_lane_merge.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fft_lane_merge_pkg.sv
// Shared types and constants for the fft_lane_merge block.
package fft_lane_merge_pkg;

    typedef enum logic {
        ST_MERGE  = 1'b0,
        ST_RESYNC = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/fft_lane_merge_lane.sv
// One lane of fft_lane_merge: a word FIFO (data plus tlast) together with the
// done flag and the drain-pop logic used while the merger resynchronizes.
module fft_lane_merge_lane
    import fft_lane_merge_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int FIFO_SIZE_LOG2 = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    input  logic              merge_pop,
    input  logic              resync,
    input  logic              done_clr,
    output logic              done
);

    localparam int DEPTH = 1 << FIFO_SIZE_LOG2;

    logic [DATA_W:0]         mem [DEPTH];
    logic [FIFO_SIZE_LOG2:0] wr_ptr;
    logic [FIFO_SIZE_LOG2:0] rd_ptr;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    drain_pop;
    logic                    pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_SIZE_LOG2] != rd_ptr[FIFO_SIZE_LOG2]) &&
                       (wr_ptr[FIFO_SIZE_LOG2-1:0] == rd_ptr[FIFO_SIZE_LOG2-1:0]);
    assign in_ready  = en && !full;
    assign push      = in_valid && in_ready;
    assign drain_pop = resync && !done && !empty;
    assign pop       = merge_pop || drain_pop;

    assign head_valid = !empty;
    assign {head_last, head_data} = mem[rd_ptr[FIFO_SIZE_LOG2-1:0]];

    // Storage write; data words are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_SIZE_LOG2-1:0]] <= {in_last, in_data};
        end
    end

    // Read and write pointers; reset discards everything buffered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Done flag: set when the drain pops this lane's tlast word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (done_clr) begin
            done <= 1'b0;
        end else if (drain_pop && head_last) begin
            done <= 1'b1;
        end
    end

endmodule

// File: rtl/fft_lane_merge.sv
// fft_lane_merge: merges NIPC single-item lane streams into one NIPC-wide
// AXI-Stream, checking that all lanes agree on packet boundaries and
// draining every lane to its next tlast when they do not.
// Optional: define FFT_LANE_MERGE_ERR_CNT_EN to add the saturating err_count.
module fft_lane_merge
    import fft_lane_merge_pkg::*;
#(
    parameter int NIPC           = 4,
    parameter int DATA_W         = 32,
    parameter int FIFO_SIZE_LOG2 = 5,
    parameter int MAX_PKT_LOG2   = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NIPC*DATA_W-1:0] i_tdata,
    input  logic [NIPC-1:0]        i_tlast,
    input  logic [NIPC-1:0]        i_tvalid,
    output logic [NIPC-1:0]        i_tready,
    output logic [NIPC*DATA_W-1:0] o_tdata,
    output logic                   o_tlast,
    output logic                   o_tvalid,
    input  logic                   o_tready,
    output logic                   event_misalign
`ifdef FFT_LANE_MERGE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]   err_count
`endif
);

    localparam logic [MAX_PKT_LOG2-1:0] BEAT_MAX = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic                    run;
    logic                    active;
    logic [NIPC-1:0]         head_valid;
    logic [NIPC-1:0]         head_last;
    logic [NIPC-1:0]         done;
    logic                    all_valid;
    logic                    last_all;
    logic                    last_any;
    logic                    over_len;
    logic                    misalign;
    logic                    merge_pop;
    logic                    resync;
    logic                    done_clr;
    logic [MAX_PKT_LOG2-1:0] beat_cnt;

    // Nothing is accepted or presented until one clean cycle out of reset.
    assign active    = rst_n && run;
    assign all_valid = &head_valid;
    assign last_all  = &head_last;
    assign last_any  = |head_last;
    assign over_len  = (beat_cnt == BEAT_MAX) && !last_any;
    assign o_tlast   = last_all;
    assign event_misalign = misalign;

    for (genvar k = 0; k < NIPC; k++) begin : g_lane
        fft_lane_merge_lane #(
            .DATA_W         (DATA_W),
            .FIFO_SIZE_LOG2 (FIFO_SIZE_LOG2)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (active),
            .in_data    (i_tdata[k*DATA_W +: DATA_W]),
            .in_last    (i_tlast[k]),
            .in_valid   (i_tvalid[k]),
            .in_ready   (i_tready[k]),
            .head_data  (o_tdata[k*DATA_W +: DATA_W]),
            .head_last  (head_last[k]),
            .head_valid (head_valid[k]),
            .merge_pop  (merge_pop),
            .resync     (resync),
            .done_clr   (done_clr),
            .done       (done[k])
        );
    end

    // Run flag: rises on the first clock edge with reset released.
    always_ff @(posedge clk) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_MERGE;
        else        state <= state_nxt;
    end

    // Head comparison, output handshake and resync sequencing.
    always_comb begin
        state_nxt = state;
        o_tvalid  = 1'b0;
        misalign  = 1'b0;
        merge_pop = 1'b0;
        resync    = 1'b0;
        done_clr  = 1'b0;
        if (active) begin
            case (state)
                ST_MERGE: begin
                    if (all_valid) begin
                        if ((last_any && !last_all) || over_len) begin
                            misalign  = 1'b1;
                            state_nxt = ST_RESYNC;
                        end else begin
                            o_tvalid  = 1'b1;
                            merge_pop = o_tready;
                        end
                    end
                end
                ST_RESYNC: begin
                    resync = 1'b1;
                    if (&done) begin
                        done_clr  = 1'b1;
                        state_nxt = ST_MERGE;
                    end
                end
                default: state_nxt = ST_MERGE;
            endcase
        end
    end

    // Beat counter within the current packet; restarts after tlast or resync.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (done_clr) begin
            beat_cnt <= '0;
        end else if (o_tvalid && o_tready) begin
            beat_cnt <= o_tlast ? '0 : beat_cnt + 1'b1;
        end
    end

`ifdef FFT_LANE_MERGE_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign err_count = err_cnt;

    // Misalignment event counter, sticking at all ones.
    always_ff @(posedge clk) begin
        if (!rst_n)        err_cnt <= '0;
        else if (misalign) err_cnt <= sat_inc(err_cnt);
    end
`endif

endmodule
